pulse_stretch: RTL and testbench
================================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 50_000_000: level_out high time in clk cycles, legal range 1..2^32-1.
REQ-002 SHALL have parameter GAP_CYC, default 0: forced low time after each hold, in cycles, legal range 0..2^32-1.
REQ-003 SHALL have parameter RETRIG, default 0: 1 = trigger during hold restarts hold; 0 = trigger during hold is dropped.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port pulse_in  input  1: trigger, sampled each clk edge, nominally one-cycle pulses.
REQ-007 SHALL have port level_out  output  1: stretched level.
REQ-008 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1: one-cycle pulse marking end of each hold.
REQ-010 SHALL have port drop_cnt  output  8: saturating count of dropped triggers.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD, GAP; state, counter and all outputs registered.
REQ-012 IDLE: pulse_in=1 at edge k -> HOLD at k; level_out high from cycle k+1 for exactly HOLD_CYC cycles.
REQ-013 HOLD: down-counter loaded with HOLD_CYC-1 on entry, decrements each cycle; leaves HOLD at the edge where it reads 0.
REQ-014 HOLD exit: GAP_CYC>0 -> GAP, counter loaded GAP_CYC-1; GAP_CYC=0 -> IDLE.
REQ-015 GAP: level_out low; exit to IDLE at the edge where counter reads 0, i.e. exactly GAP_CYC low cycles before a new trigger is accepted.
REQ-016 done SHALL be high for exactly the first cycle level_out is low after a hold, including when GAP_CYC=0.
REQ-017 RETRIG=1: pulse_in=1 in any HOLD cycle, last one included, reloads counter to HOLD_CYC-1; level_out stays high HOLD_CYC cycles after that trigger; no done, no gap between.
REQ-018 RETRIG=0: pulse_in=1 in any HOLD cycle is ignored and increments drop_cnt.
REQ-019 pulse_in=1 in any GAP cycle SHALL be ignored and increment drop_cnt, regardless of RETRIG.
REQ-020 GAP_CYC=0, trigger in the cycle after the last high cycle (state IDLE) SHALL be accepted; level_out then shows exactly one low cycle.
REQ-021 drop_cnt SHALL saturate at 255 and hold; it is cleared only by rst.
REQ-022 pulse_in held high continuously SHALL count as one trigger per cycle; RETRIG=1 therefore keeps level_out high.
REQ-023 HOLD_CYC=1 SHALL give a one-cycle level_out pulse delayed one cycle from pulse_in.
REQ-024 Counter width SHALL be $clog2 of the larger of HOLD_CYC and GAP_CYC, minimum 1; it never wraps below 0.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, counter 0, level_out 0, busy 0, done 0, drop_cnt 0.
REQ-026 rst during HOLD or GAP SHALL abort with no done pulse; rst has priority over pulse_in in the same cycle.
REQ-027 First trigger accepted SHALL be at the first edge with rst=0.

Structure
REQ-028 State encodings (IDLE=2'd0, HOLD=2'd1, GAP=2'd2) SHALL reside in a shared package/include file pulse_stretch_pkg for reuse by bench and other control blocks.
REQ-029 No sub-module SHALL be used; the counter and FSM are inline in pulse_stretch.

Verification (HOLD_CYC=5, GAP_CYC=3 unless stated)
REQ-030 Single pulse at cycle 10, RETRIG=0 -> level_out high cycles 11-15; done cycle 16; busy 10-18; drop_cnt 0.
REQ-031 RETRIG=0, pulses at 10 and 13 -> level_out high 11-15 only; drop_cnt=1.
REQ-032 RETRIG=1, pulses at 10 and 13 -> level_out high 11-18; one done at 19.
REQ-033 Pulse at 17 (GAP) then 19 -> 17 dropped (drop_cnt=1); 19 accepted, level_out high 20-24.
REQ-034 GAP_CYC=0, pulses at 10 and 16 -> level_out high 11-15, low 16, high 17-21; done at 16 and 22.
REQ-035 rst asserted cycle 13 during hold; 300 RETRIG=0 hold-time pulses pre-reset -> level_out 0 from cycle 14, no done, drop_cnt 255 saturated before reset, 0 after.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared state encodings and sizing helper for the pulse stretcher and its neighbours.
package pulse_stretch_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   // Down-counter width: enough bits for the larger of the two reload values, never zero.
   function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                             input int unsigned gap_cyc);
      int unsigned m;
      m = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
      return (m <= 32'd1) ? 32'd1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches trigger pulses into a fixed-length level, with optional retrigger and
// a forced low gap after each hold; dropped triggers are counted.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned HOLD_CYC = 50_000_000,
   parameter int unsigned GAP_CYC  = 0,
   parameter bit          RETRIG   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pulse_in,
   output logic       level_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] drop_cnt
);

   localparam int unsigned CW = cnt_width(HOLD_CYC, GAP_CYC);
   localparam logic [CW-1:0] HoldLoad = CW'(HOLD_CYC - 32'd1);
   localparam logic [CW-1:0] GapLoad  = CW'((GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, busy_q, done_q;
   logic [7:0]    drop_q;
   logic          drop_evt;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      drop_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (pulse_in) begin
               state_d = HOLD;
               cnt_d   = HoldLoad;
            end
         end
         HOLD: begin
            drop_evt = pulse_in && !RETRIG;
            if (pulse_in && RETRIG) begin
               cnt_d = HoldLoad;
            end else if (cnt_q == '0) begin
               if (GAP_CYC > 32'd0) begin
                  state_d = GAP;
                  cnt_d   = GapLoad;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            drop_evt = pulse_in;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs trail the state by one cycle so level_out starts the cycle after the trigger;
   // busy spans from trigger acceptance to the last visible gap cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= (state_q == HOLD);
         busy_q  <= (state_q != IDLE) || (state_d != IDLE);
         done_q  <= level_q && (state_q != HOLD);
         if (drop_evt && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

   assign level_out = level_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench: five parameterisations share one stimulus; per-cycle mask vectors plus
// hand-written reset and saturation sequences.
module tb_pulse_stretch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pulse = 1'b0;
   logic       lvl [5];
   logic       bsy [5];
   logic       dn  [5];
   logic [7:0] drp [5];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   // 0: 5/3/0  1: 5/3/1  2: 5/0/0  3: 1/0/0  4: 400/3/0  (HOLD/GAP/RETRIG)
   pulse_stretch #(.HOLD_CYC(5), .GAP_CYC(3), .RETRIG(1'b0)) u_a (
      .clk(clk), .rst(rst), .pulse_in(pulse),
      .level_out(lvl[0]), .busy(bsy[0]), .done(dn[0]), .drop_cnt(drp[0]));
   pulse_stretch #(.HOLD_CYC(5), .GAP_CYC(3), .RETRIG(1'b1)) u_b (
      .clk(clk), .rst(rst), .pulse_in(pulse),
      .level_out(lvl[1]), .busy(bsy[1]), .done(dn[1]), .drop_cnt(drp[1]));
   pulse_stretch #(.HOLD_CYC(5), .GAP_CYC(0), .RETRIG(1'b0)) u_c (
      .clk(clk), .rst(rst), .pulse_in(pulse),
      .level_out(lvl[2]), .busy(bsy[2]), .done(dn[2]), .drop_cnt(drp[2]));
   pulse_stretch #(.HOLD_CYC(1), .GAP_CYC(0), .RETRIG(1'b0)) u_d (
      .clk(clk), .rst(rst), .pulse_in(pulse),
      .level_out(lvl[3]), .busy(bsy[3]), .done(dn[3]), .drop_cnt(drp[3]));
   pulse_stretch #(.HOLD_CYC(400), .GAP_CYC(3), .RETRIG(1'b0)) u_e (
      .clk(clk), .rst(rst), .pulse_in(pulse),
      .level_out(lvl[4]), .busy(bsy[4]), .done(dn[4]), .drop_cnt(drp[4]));

   typedef struct {
      int          inst;
      logic [31:0] pulses;
      logic [31:0] exp_lvl;
      logic [31:0] exp_dn;
      logic [31:0] exp_bsy;
      logic [7:0]  exp_drop;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   // Drive inputs for the next rising edge, then sample just after it.
   task automatic step(input logic p, input logic r);
      @(negedge clk);
      pulse = p;
      rst   = r;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_all();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      cyc = 0;
   endtask

   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] b(input int k);
      return 32'd1 << k;
   endfunction

   initial begin
      vecs[0] = '{0, b(10),               rng(11, 15),             b(16),         rng(10, 18),
                  8'd0};
      vecs[1] = '{0, b(10) | b(13),       rng(11, 15),             b(16),         rng(10, 18),
                  8'd1};
      vecs[2] = '{1, b(10) | b(13),       rng(11, 18),             b(19),         rng(10, 21),
                  8'd0};
      vecs[3] = '{0, b(10) | b(17) | b(19), rng(11, 15) | rng(20, 24), b(16) | b(25),
                  rng(10, 27), 8'd1};
      vecs[4] = '{2, b(10) | b(16),       rng(11, 15) | rng(17, 21), b(16) | b(22),
                  rng(10, 21), 8'd0};
      vecs[5] = '{3, b(5) | b(8) | b(9),  b(6) | b(9),             b(7) | b(10),
                  b(5) | b(6) | b(8) | b(9), 8'd1};
      vecs[6] = '{1, rng(10, 20),         rng(11, 25),             b(26),         rng(10, 28),
                  8'd0};

      reset_all();
      for (int i = 0; i < 5; i++) begin
         check("reset level", 32'(lvl[i]), 32'd0);
         check("reset busy",  32'(bsy[i]), 32'd0);
         check("reset done",  32'(dn[i]),  32'd0);
         check("reset drop",  32'(drp[i]), 32'd0);
      end

      foreach (vecs[v]) begin
         reset_all();
         for (int c = 1; c < 32; c++) begin
            step(vecs[v].pulses[c], 1'b0);
            check($sformatf("vec%0d level", v), 32'(lvl[vecs[v].inst]), 32'(vecs[v].exp_lvl[c]));
            check($sformatf("vec%0d done", v),  32'(dn[vecs[v].inst]),  32'(vecs[v].exp_dn[c]));
            check($sformatf("vec%0d busy", v),  32'(bsy[vecs[v].inst]), 32'(vecs[v].exp_bsy[c]));
         end
         check($sformatf("vec%0d drop", v), 32'(drp[vecs[v].inst]), 32'(vecs[v].exp_drop));
      end

      // Reset mid-hold, with a coincident trigger that must lose to rst.
      reset_all();
      for (int c = 1; c <= 13; c++) step(c == 10, 1'b0);
      check("midhold level before rst", 32'(lvl[0]), 32'd1);
      step(1'b1, 1'b1);
      check("rst level", 32'(lvl[0]), 32'd0);
      check("rst busy",  32'(bsy[0]), 32'd0);
      check("rst done",  32'(dn[0]),  32'd0);
      for (int c = 15; c <= 20; c++) begin
         step(1'b0, 1'b0);
         check("post-rst done",  32'(dn[0]),  32'd0);
         check("post-rst level", 32'(lvl[0]), 32'd0);
      end

      // 300 triggers inside one long hold saturate the drop counter.
      reset_all();
      step(1'b1, 1'b0);
      for (int k = 1; k <= 300; k++) begin
         step(1'b1, 1'b0);
         if (k == 254) check("drop 254", 32'(drp[4]), 32'd254);
      end
      check("drop saturated", 32'(drp[4]), 32'd255);
      check("long hold level", 32'(lvl[4]), 32'd1);
      step(1'b1, 1'b1);
      check("sat rst drop",  32'(drp[4]), 32'd0);
      check("sat rst level", 32'(lvl[4]), 32'd0);
      check("sat rst busy",  32'(bsy[4]), 32'd0);
      check("sat rst done",  32'(dn[4]),  32'd0);
      step(1'b1, 1'b0);
      check("first edge trigger busy",  32'(bsy[4]), 32'd1);
      check("first edge trigger level", 32'(lvl[4]), 32'd0);
      step(1'b0, 1'b0);
      check("first edge trigger level next", 32'(lvl[4]), 32'd1);
      check("first edge drop", 32'(drp[4]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
